// File: rtl/i2c_pkg.sv
// i2c_pkg: types and constants shared by the codec I2C target and the codec-init master.
package i2c_pkg;
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ACK_A,
        ST_REG_HI,
        ST_ACK_H,
        ST_REG_LO,
        ST_ACK_L,
        ST_IGNORE
    } i2c_state_t;

    localparam logic [6:0] DEV_ADDR_CODEC  = 7'b0011010;
    localparam int         CODEC_NUM_REGS  = 10;
    localparam int         I2C_SYNC_STAGES = 2;

    typedef struct packed {
        logic start;
        logic stop;
        logic scl_rise;
        logic scl_fall;
        logic sda;
    } i2c_evt_t;
endpackage

// File: rtl/i2c_line_sync.sv
// i2c_line_sync: synchronizes SCL/SDA and flags SCL edges plus START/STOP conditions.
module i2c_line_sync
    import i2c_pkg::*;
#(
    parameter int SYNC_STAGES = I2C_SYNC_STAGES
) (
    input  logic     i_clk,
    input  logic     i_rst,
    input  logic     i_scl,
    input  logic     i_sda,
    output i2c_evt_t o_evt
);
    logic [SYNC_STAGES-1:0] scl_q, sda_q;
    logic                   scl_d, sda_d;
    logic                   scl_s, sda_s;

    assign scl_s = scl_q[SYNC_STAGES-1];
    assign sda_s = sda_q[SYNC_STAGES-1];

    // Reset to the idle bus level so leaving reset never fakes an edge.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            scl_q <= '1;
            sda_q <= '1;
            scl_d <= 1'b1;
            sda_d <= 1'b1;
        end else begin
            scl_q <= SYNC_STAGES'({scl_q, i_scl});
            sda_q <= SYNC_STAGES'({sda_q, i_sda});
            scl_d <= scl_s;
            sda_d <= sda_s;
        end
    end

    assign o_evt = '{
        start:    scl_d & scl_s & sda_d & ~sda_s,
        stop:     scl_d & scl_s & ~sda_d & sda_s,
        scl_rise: ~scl_d & scl_s,
        scl_fall: scl_d & ~scl_s,
        sda:      sda_s
    };
endmodule

// File: rtl/i2c_codec_target.sv
// i2c_codec_target: write-only I2C target for the codec control port.
// Frames are START, address byte, {reg_addr, data[8]}, data[7:0], STOP.
module i2c_codec_target
    import i2c_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR    = DEV_ADDR_CODEC,
    parameter int         NUM_REGS    = CODEC_NUM_REGS,
    parameter int         SYNC_STAGES = I2C_SYNC_STAGES
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_scl,
    input  logic       i_sda,
    output logic       o_sda_pull,
    output logic       o_wr_valid,
    output logic [6:0] o_wr_addr,
    output logic [8:0] o_wr_data,
    output logic       o_err,
    output logic       o_busy,
    input  logic [3:0] i_rd_addr,
    output logic [8:0] o_rd_data
);
    localparam logic [6:0] NREG7 = 7'(NUM_REGS);
    localparam logic [3:0] NREG4 = 4'(NUM_REGS);

    i2c_evt_t   ev;
    i2c_state_t state;
    logic [7:0] shreg, hi;
    logic [2:0] bcnt;
    logic       full, commit, armed;
    logic [8:0] regs [NUM_REGS];

    i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_scl (i_scl),
        .i_sda (i_sda),
        .o_evt (ev)
    );

    assign o_rd_data = (i_rd_addr < NREG4) ? regs[i_rd_addr] : '0;

    always_ff @(posedge i_clk) begin
        o_wr_valid <= 1'b0;
        o_err      <= 1'b0;
        commit     <= 1'b0;
        if (i_rst) begin
            state      <= ST_IDLE;
            shreg      <= '0;
            hi         <= '0;
            bcnt       <= '0;
            full       <= 1'b0;
            armed      <= 1'b0;
            o_sda_pull <= 1'b0;
            o_busy     <= 1'b0;
            o_wr_addr  <= '0;
            o_wr_data  <= '0;
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else if (ev.start || ev.stop) begin
            state      <= ev.start ? ST_ADDR : ST_IDLE;
            o_busy     <= ev.start;
            bcnt       <= '0;
            full       <= 1'b0;
            armed      <= 1'b0;
            o_sda_pull <= 1'b0;
        end else begin
            if (commit) begin
                if (hi[7:1] < NREG7) begin
                    regs[hi[4:1]] <= {hi[0], shreg};
                    o_wr_valid    <= 1'b1;
                    o_wr_addr     <= hi[7:1];
                    o_wr_data     <= {hi[0], shreg};
                end else begin
                    o_err <= 1'b1;
                end
            end
            case (state)
                ST_ADDR, ST_REG_HI, ST_REG_LO, ST_IGNORE: begin
                    if (ev.scl_rise) begin
                        shreg  <= {shreg[6:0], ev.sda};
                        bcnt   <= bcnt + 3'd1;
                        full   <= bcnt == 3'd7;
                        commit <= state == ST_REG_LO && bcnt == 3'd7;
                        if (state == ST_IGNORE && armed && bcnt == 3'd7) begin
                            o_err <= 1'b1;
                            armed <= 1'b0;
                        end
                    end else if (ev.scl_fall && full) begin
                        full <= 1'b0;
                        if (state == ST_ADDR) begin
                            state      <= (shreg == {DEV_ADDR, 1'b0}) ? ST_ACK_A : ST_IGNORE;
                            o_sda_pull <= shreg == {DEV_ADDR, 1'b0};
                        end else if (state != ST_IGNORE) begin
                            state      <= (state == ST_REG_HI) ? ST_ACK_H : ST_ACK_L;
                            hi         <= (state == ST_REG_HI) ? shreg : hi;
                            o_sda_pull <= 1'b1;
                        end
                    end
                end
                ST_ACK_A, ST_ACK_H, ST_ACK_L: begin
                    if (ev.scl_fall) begin
                        o_sda_pull <= 1'b0;
                        armed      <= state == ST_ACK_L;
                        state      <= (state == ST_ACK_A) ? ST_REG_HI :
                                      (state == ST_ACK_H) ? ST_REG_LO : ST_IGNORE;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_i2c_codec_target.sv
// tb_i2c_codec_target: directed I2C master stimulus against the codec target.
module tb_i2c_codec_target;
    logic       clk = 1'b0, rst = 1'b1, scl = 1'b1, sda_drv = 1'b1;
    logic [3:0] rd_addr = '0;
    logic       sda_pull, wr_valid, err, busy, sda_bus;
    logic [6:0] wr_addr;
    logic [8:0] wr_data, rd_data;

    int checks = 0, failures = 0;
    int wr_cnt = 0, err_cnt = 0, pull_cyc = 0, bad_pull = 0;
    logic in_ack = 1'b0;
    logic [8:0] exp_regs [10];
    logic [8:0] cfg [10] = '{9'h017, 9'h017, 9'h179, 9'h079, 9'h012,
                             9'h000, 9'h162, 9'h04A, 9'h000, 9'h001};

    assign sda_bus = sda_drv & ~sda_pull;
    always #5 clk = ~clk;

    i2c_codec_target dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_scl      (scl),
        .i_sda      (sda_bus),
        .o_sda_pull (sda_pull),
        .o_wr_valid (wr_valid),
        .o_wr_addr  (wr_addr),
        .o_wr_data  (wr_data),
        .o_err      (err),
        .o_busy     (busy),
        .i_rd_addr  (rd_addr),
        .o_rd_data  (rd_data)
    );

    always @(negedge clk) begin
        if (wr_valid) wr_cnt++;
        if (err) err_cnt++;
        if (sda_pull) pull_cyc++;
        if (scl && sda_pull && !in_ack) bad_pull++;
    end

    task automatic wt(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic i2c_start();
        sda_drv = 1'b1; wt(4);
        scl = 1'b1; wt(4);
        sda_drv = 1'b0; wt(4);
        scl = 1'b0; wt(4);
    endtask

    task automatic i2c_stop();
        sda_drv = 1'b0; wt(4);
        scl = 1'b1; wt(4);
        sda_drv = 1'b1; wt(8);
    endtask

    task automatic send_bits(input logic [7:0] b, input int n);
        for (int i = 7; i > 7 - n; i--) begin
            sda_drv = b[i]; wt(4);
            scl = 1'b1; wt(8);
            scl = 1'b0; wt(4);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        send_bits(b, 8);
        sda_drv = 1'b1; in_ack = 1'b1; wt(4);
        scl = 1'b1; wt(4);
        ack = ~sda_bus; wt(4);
        scl = 1'b0; wt(1);
        in_ack = 1'b0; wt(3);
    endtask

    task automatic frame(input logic [7:0] b0, b1, b2, output logic [2:0] acks);
        i2c_start();
        send_byte(b0, acks[2]);
        send_byte(b1, acks[1]);
        send_byte(b2, acks[0]);
        i2c_stop();
    endtask

    task automatic test_reset();
        wt(4); rst = 1'b0; wt(2);
        checks++;
        if ({sda_pull, wr_valid, err, busy, wr_addr, wr_data} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got pull=%b wv=%b err=%b busy=%b wa=%h wd=%h want all 0",
                     sda_pull, wr_valid, err, busy, wr_addr, wr_data);
        end
        for (int i = 0; i < 16; i++) begin
            rd_addr = 4'(i); #1;
            checks++;
            if (rd_data !== 9'h000) begin
                failures++; $display("FAIL reset_reg%0d got %h want 000", i, rd_data);
            end
        end
        for (int i = 0; i < 10; i++) exp_regs[i] = '0;
    endtask

    task automatic test_single_write();
        logic a0, a1, a2;
        int w0 = wr_cnt, e0 = err_cnt;
        i2c_start();
        checks++;
        if (busy !== 1'b1) begin failures++; $display("FAIL single_busy got %b want 1", busy); end
        send_byte(8'h34, a0); send_byte(8'h12, a1); send_byte(8'h17, a2);
        i2c_stop();
        exp_regs[9] = 9'h017;
        checks++;
        if ({a0, a1, a2} !== 3'b111) begin failures++; $display("FAIL single_acks got %b want 111", {a0, a1, a2}); end
        checks++;
        if (wr_cnt - w0 !== 1) begin failures++; $display("FAIL single_wr_count got %0d want 1", wr_cnt - w0); end
        checks++;
        if (err_cnt !== e0) begin failures++; $display("FAIL single_err got %0d want 0", err_cnt - e0); end
        checks++;
        if (wr_addr !== 7'd9 || wr_data !== 9'h017) begin
            failures++; $display("FAIL single_wr_port got %0d/%h want 9/017", wr_addr, wr_data);
        end
        rd_addr = 4'd9; #1;
        checks++;
        if (rd_data !== 9'h017) begin failures++; $display("FAIL single_rd got %h want 017", rd_data); end
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL single_busy_end got %b want 0", busy); end
    endtask

    task automatic test_config_stream();
        logic [2:0] acks;
        logic [6:0] a;
        int w0 = wr_cnt;
        for (int r = 0; r < 10; r++) begin
            a = 7'(r);
            frame({a, cfg[r][8]}, cfg[r][7:0], 8'h00, acks);
            frame(8'h34, {a, cfg[r][8]}, cfg[r][7:0], acks);
            exp_regs[r] = cfg[r];
            checks++;
            if (acks !== 3'b111 || busy !== 1'b0) begin
                failures++; $display("FAIL cfg_frame%0d acks=%b busy=%b want 111/0", r, acks, busy);
            end
        end
        checks++;
        if (wr_cnt - w0 !== 10) begin failures++; $display("FAIL cfg_wr_count got %0d want 10", wr_cnt - w0); end
        checks++;
        if (wr_addr !== 7'd9 || wr_data !== cfg[9]) begin
            failures++; $display("FAIL cfg_last_write got %0d/%h want 9/%h", wr_addr, wr_data, cfg[9]);
        end
        for (int i = 0; i < 10; i++) begin
            rd_addr = 4'(i); #1;
            checks++;
            if (rd_data !== exp_regs[i]) begin
                failures++; $display("FAIL cfg_reg%0d got %h want %h", i, rd_data, exp_regs[i]);
            end
        end
    endtask

    task automatic test_addr_mismatch();
        logic [2:0] acks;
        int w0 = wr_cnt, e0 = err_cnt, p0 = pull_cyc;
        frame(8'h36, 8'h02, 8'h99, acks);
        checks++;
        if (acks !== 3'b000) begin failures++; $display("FAIL mismatch_acks got %b want 000", acks); end
        checks++;
        if (pull_cyc !== p0) begin failures++; $display("FAIL mismatch_pull got %0d cycles want 0", pull_cyc - p0); end
        checks++;
        if (wr_cnt !== w0 || err_cnt !== e0) begin
            failures++; $display("FAIL mismatch_wr_err got wr=%0d err=%0d want 0/0", wr_cnt - w0, err_cnt - e0);
        end
        rd_addr = 4'd1; #1;
        checks++;
        if (rd_data !== exp_regs[1]) begin failures++; $display("FAIL mismatch_reg1 got %h want %h", rd_data, exp_regs[1]); end
    endtask

    task automatic test_bad_reg();
        logic [2:0] acks;
        int w0 = wr_cnt, e0 = err_cnt;
        frame(8'h34, 8'h1E, 8'h55, acks);
        checks++;
        if (acks !== 3'b111) begin failures++; $display("FAIL badreg_acks got %b want 111", acks); end
        checks++;
        if (err_cnt - e0 !== 1 || wr_cnt !== w0) begin
            failures++; $display("FAIL badreg_err_wr got err=%0d wr=%0d want 1/0", err_cnt - e0, wr_cnt - w0);
        end
        for (int i = 0; i < 10; i++) begin
            rd_addr = 4'(i); #1;
            checks++;
            if (rd_data !== exp_regs[i]) begin
                failures++; $display("FAIL badreg_reg%0d got %h want %h", i, rd_data, exp_regs[i]);
            end
        end
    endtask

    task automatic test_overrun();
        logic a0, a1, a2, a3;
        int w0 = wr_cnt, e0 = err_cnt;
        i2c_start();
        send_byte(8'h34, a0); send_byte(8'h02, a1); send_byte(8'h33, a2); send_byte(8'hAA, a3);
        send_byte(8'hBB, a3);
        i2c_stop();
        exp_regs[1] = 9'h033;
        checks++;
        if ({a0, a1, a2, a3} !== 4'b1110) begin failures++; $display("FAIL overrun_acks got %b want 1110", {a0, a1, a2, a3}); end
        checks++;
        if (err_cnt - e0 !== 1 || wr_cnt - w0 !== 1) begin
            failures++; $display("FAIL overrun_err_wr got err=%0d wr=%0d want 1/1", err_cnt - e0, wr_cnt - w0);
        end
        rd_addr = 4'd1; #1;
        checks++;
        if (rd_data !== 9'h033) begin failures++; $display("FAIL overrun_reg1 got %h want 033", rd_data); end
    endtask

    task automatic test_abort_restart();
        logic a;
        logic [2:0] acks;
        int w0 = wr_cnt;
        i2c_start();
        send_byte(8'h34, a); send_byte(8'h04, a);
        i2c_stop();
        checks++;
        if (busy !== 1'b0 || wr_cnt !== w0) begin
            failures++; $display("FAIL abort_stop got busy=%b wr=%0d want 0/0", busy, wr_cnt - w0);
        end
        i2c_start();
        send_byte(8'h34, a); send_byte(8'h06, a);
        send_bits(8'hFF, 4);
        frame(8'h34, 8'h08, 8'h5A, acks);
        exp_regs[4] = 9'h05A;
        checks++;
        if (acks !== 3'b111 || wr_cnt - w0 !== 1) begin
            failures++; $display("FAIL restart_frame got acks=%b wr=%0d want 111/1", acks, wr_cnt - w0);
        end
        for (int i = 2; i < 5; i++) begin
            rd_addr = 4'(i); #1;
            checks++;
            if (rd_data !== exp_regs[i]) begin
                failures++; $display("FAIL restart_reg%0d got %h want %h", i, rd_data, exp_regs[i]);
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        logic a;
        logic [2:0] acks;
        i2c_start();
        send_byte(8'h34, a);
        send_bits(8'h02, 8);
        sda_drv = 1'b1; in_ack = 1'b1; wt(2);
        checks++;
        if (sda_pull !== 1'b1) begin failures++; $display("FAIL rstmid_ack_h got pull=%b want 1", sda_pull); end
        rst = 1'b1; wt(1);
        checks++;
        if (sda_pull !== 1'b0 || busy !== 1'b0) begin
            failures++; $display("FAIL rstmid_release got pull=%b busy=%b want 0/0", sda_pull, busy);
        end
        rst = 1'b0; in_ack = 1'b0;
        for (int i = 0; i < 10; i++) begin
            rd_addr = 4'(i); #1;
            checks++;
            if (rd_data !== 9'h000) begin failures++; $display("FAIL rstmid_reg%0d got %h want 000", i, rd_data); end
        end
        i2c_stop();
        frame(8'h34, 8'h07, 8'hAB, acks);
        rd_addr = 4'd3; #1;
        checks++;
        if (acks !== 3'b111 || rd_data !== 9'h1AB) begin
            failures++; $display("FAIL rstmid_after got acks=%b reg3=%h want 111/1ab", acks, rd_data);
        end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_config_stream();
        test_addr_mismatch();
        test_bad_reg();
        test_overrun();
        test_abort_restart();
        test_reset_mid_frame();
        checks++;
        if (bad_pull !== 0) begin failures++; $display("FAIL pull_while_scl_high got %0d cycles want 0", bad_pull); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
